// File: rtl/qspi_ddr_rx.sv
// qspi_ddr_rx: receive side of a quad-SPI DDR read burst.
// Skips a programmable number of dummy cycles, then assembles bytes from
// the input-DDR nibble pair into 32-bit words, MSB-first, one strobe per word.
module qspi_ddr_rx #(
    parameter int OPT_SKEW = 0,
    parameter int LGLEN    = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [LGLEN-1:0] i_len,
    input  logic [3:0]       i_dummy,
    input  logic             i_abort,
    input  logic             i_ce,
    input  logic [7:0]       i_dat,
    output logic             o_busy,
    output logic             o_stb,
    output logic [31:0]      o_word,
    output logic             o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DUMMY = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [LGLEN-1:0] ONE_WORD = LGLEN'(1);

    state_t           r_state;
    state_t           w_next;
    logic [LGLEN-1:0] r_words;
    logic [3:0]       r_dummy;
    logic [3:0]       r_nib;
    logic [1:0]       r_bcnt;
    logic [23:0]      r_sreg;
    logic [31:0]      r_word;
    logic             r_stb;
    logic             r_done;

    logic [7:0]       w_byte;
    logic             w_start_ok;
    logic             w_dummy_end;
    logic             w_word_end;

    // With skew, the rising nibble of this cycle completes the byte begun
    // on the previous enabled cycle's falling edge.
    always_comb begin
        w_byte      = (OPT_SKEW != 0) ? {r_nib, i_dat[7:4]} : i_dat;
        w_start_ok  = (r_state == IDLE) && i_start && !i_abort;
        w_dummy_end = (r_state == DUMMY) && i_ce && !i_abort && (r_dummy == 4'd1);
        w_word_end  = (r_state == DATA) && i_ce && !i_abort && (r_bcnt == 2'd3);
    end

    // Next-state logic: abort wins over everything except reset.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    if (i_dummy != 4'd0)
                        w_next = DUMMY;
                    else if (i_len != '0)
                        w_next = DATA;
                end
            end
            DUMMY: begin
                if (i_abort)
                    w_next = IDLE;
                else if (w_dummy_end)
                    w_next = (r_words == '0) ? IDLE : DATA;
            end
            DATA: begin
                if (i_abort)
                    w_next = IDLE;
                else if (w_word_end && (r_words == ONE_WORD))
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register plus counters, nibble hold, shift register and outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_words <= '0;
            r_dummy <= 4'd0;
            r_nib   <= 4'd0;
            r_bcnt  <= 2'd0;
            r_sreg  <= 24'd0;
            r_word  <= 32'd0;
            r_stb   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_stb   <= 1'b0;
            r_done  <= 1'b0;
            if (r_state == IDLE) begin
                if (w_start_ok) begin
                    r_words <= i_len;
                    r_dummy <= i_dummy;
                    r_nib   <= 4'd0;
                    r_bcnt  <= 2'd0;
                    if ((i_dummy == 4'd0) && (i_len == '0))
                        r_done <= 1'b1;
                end
            end else if (i_abort) begin
                r_words <= '0;
                r_dummy <= 4'd0;
                r_bcnt  <= 2'd0;
            end else if (i_ce) begin
                r_nib <= i_dat[3:0];
                if (r_state == DUMMY) begin
                    r_dummy <= r_dummy - 4'd1;
                    if (w_dummy_end && (r_words == '0))
                        r_done <= 1'b1;
                end else begin
                    r_sreg <= {r_sreg[15:0], w_byte};
                    r_bcnt <= r_bcnt + 2'd1;
                    if (w_word_end) begin
                        r_word  <= {r_sreg, w_byte};
                        r_stb   <= 1'b1;
                        r_words <= r_words - ONE_WORD;
                        if (r_words == ONE_WORD)
                            r_done <= 1'b1;
                    end
                end
            end
        end
    end

    // Strobes are masked while reset is held so they can never overlap it.
    always_comb begin
        o_busy = (r_state != IDLE);
        o_stb  = r_stb && !i_reset;
        o_done = r_done && !i_reset;
        o_word = r_word;
    end

endmodule

// File: tb/tb_qspi_ddr_rx.sv
// Scoreboard bench for qspi_ddr_rx: one instance without skew, one with.
module tb_qspi_ddr_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        st0, st1;
    logic [7:0]  len;
    logic [3:0]  dummy;
    logic        abort;
    logic        ce;
    logic [7:0]  dat;

    logic        busy0, stb0, done0;
    logic [31:0] word0;
    logic        busy1, stb1, done1;
    logic [31:0] word1;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic        stb;
        logic [31:0] word;
        logic        done;
        logic        busy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    qspi_ddr_rx #(.OPT_SKEW(0), .LGLEN(8)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_start(st0), .i_len(len), .i_dummy(dummy),
        .i_abort(abort), .i_ce(ce), .i_dat(dat),
        .o_busy(busy0), .o_stb(stb0), .o_word(word0), .o_done(done0)
    );

    qspi_ddr_rx #(.OPT_SKEW(1), .LGLEN(8)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(st1), .i_len(len), .i_dummy(dummy),
        .i_abort(abort), .i_ce(ce), .i_dat(dat),
        .o_busy(busy1), .o_stb(stb1), .o_word(word1), .o_done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon_one(input string tag, input logic stb, input logic done,
                           input logic busy, input logic [31:0] word, inout exp_t q[$]);
        exp_t e;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_unexpected: got stb=%b done=%b word=%h expected no event",
                     tag, stb, done, word);
        end else begin
            e = q.pop_front();
            chk({tag, "_stb"},  32'(stb),  32'(e.stb));
            chk({tag, "_word"}, word,      e.word);
            chk({tag, "_done"}, 32'(done), 32'(e.done));
            chk({tag, "_busy"}, 32'(busy), 32'(e.busy));
        end
    endtask

    // Monitors: pop and compare whenever an instance presents a strobe or done.
    always @(negedge clk) begin
        if (mon_en && (stb0 || done0))
            mon_one("dut0", stb0, done0, busy0, word0, q0);
    end

    always @(negedge clk) begin
        if (mon_en && (stb1 || done1))
            mon_one("dut1", stb1, done1, busy1, word1, q1);
    end

    task automatic cyc(input logic c, input logic [7:0] d);
        ce  = c;
        dat = d;
        @(posedge clk);
        #1;
        ce  = 1'b0;
    endtask

    task automatic start(input bit which, input logic [7:0] l, input logic [3:0] dm);
        len   = l;
        dummy = dm;
        if (which) st1 = 1'b1; else st0 = 1'b1;
        cyc(1'b0, 8'h00);
        st0 = 1'b0;
        st1 = 1'b0;
    endtask

    function automatic exp_t mk(input logic s, input logic [31:0] w, input logic d, input logic b);
        exp_t e;
        e.stb = s; e.word = w; e.done = d; e.busy = b;
        return e;
    endfunction

    initial begin
        rst = 1'b1; st0 = 1'b0; st1 = 1'b0; len = '0; dummy = '0;
        abort = 1'b0; ce = 1'b0; dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_stb0",  32'(stb0),  32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_word0", word0,      32'd0);
        chk("rst_word1", word1,      32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        cyc(1'b0, 8'h00);

        // Single word, no dummy cycles.
        q0.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 1'b0));
        start(1'b0, 8'd1, 4'd0);
        chk("busy_after_start", 32'(busy0), 32'd1);
        cyc(1'b1, 8'hDE); cyc(1'b1, 8'hAD); cyc(1'b1, 8'hBE); cyc(1'b1, 8'hEF);
        repeat (3) cyc(1'b0, 8'h00);

        // Two words, two dummy cycles, enable toggling.
        q0.push_back(mk(1'b1, 32'h00010203, 1'b0, 1'b1));
        q0.push_back(mk(1'b1, 32'h04050607, 1'b1, 1'b0));
        start(1'b0, 8'd2, 4'd2);
        cyc(1'b1, 8'hFF); cyc(1'b0, 8'h00); cyc(1'b1, 8'hFF); cyc(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'(i));
            cyc(1'b0, 8'hCC);
        end
        repeat (3) cyc(1'b0, 8'h00);

        // Half-cycle skew: first nibble from the dummy cycle's falling edge.
        q1.push_back(mk(1'b1, 32'h12345678, 1'b1, 1'b0));
        start(1'b1, 8'd1, 4'd1);
        cyc(1'b1, 8'hA1);
        cyc(1'b1, 8'h23); cyc(1'b1, 8'h45); cyc(1'b1, 8'h67); cyc(1'b1, 8'h89);
        repeat (3) cyc(1'b0, 8'h00);

        // Abort after two bytes, then a fresh burst.
        start(1'b0, 8'd1, 4'd0);
        cyc(1'b1, 8'h11); cyc(1'b1, 8'h22);
        abort = 1'b1;
        cyc(1'b1, 8'h33);
        abort = 1'b0;
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_word_held", word0, 32'h04050607);
        repeat (3) cyc(1'b1, 8'h44);
        q0.push_back(mk(1'b1, 32'h01020304, 1'b1, 1'b0));
        start(1'b0, 8'd1, 4'd0);
        cyc(1'b1, 8'h01); cyc(1'b1, 8'h02); cyc(1'b1, 8'h03); cyc(1'b1, 8'h04);
        repeat (3) cyc(1'b0, 8'h00);

        // Zero-length burst: done only, word held.
        q0.push_back(mk(1'b0, 32'h01020304, 1'b1, 1'b0));
        start(1'b0, 8'd0, 4'd0);
        repeat (3) cyc(1'b0, 8'h00);

        // Start while busy is ignored.
        q0.push_back(mk(1'b1, 32'hA0A1A2A3, 1'b1, 1'b0));
        start(1'b0, 8'd1, 4'd0);
        cyc(1'b1, 8'hA0);
        st0 = 1'b1; len = 8'd3; dummy = 4'd5;
        cyc(1'b1, 8'hA1);
        st0 = 1'b0;
        cyc(1'b1, 8'hA2); cyc(1'b1, 8'hA3);
        repeat (6) cyc(1'b1, 8'h55);

        // Reset in the middle of the second word.
        q0.push_back(mk(1'b1, 32'h01020304, 1'b0, 1'b1));
        start(1'b0, 8'd2, 4'd0);
        cyc(1'b1, 8'h01); cyc(1'b1, 8'h02); cyc(1'b1, 8'h03); cyc(1'b1, 8'h04);
        cyc(1'b1, 8'h05); cyc(1'b1, 8'h06);
        rst = 1'b1;
        cyc(1'b1, 8'h07);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_stb",  32'(stb0),  32'd0);
        chk("midrst_done", 32'(done0), 32'd0);
        chk("midrst_word", word0,      32'd0);
        rst = 1'b0;
        repeat (4) cyc(1'b1, 8'h08);

        // Dummy cycles with zero length: done when the dummies run out.
        q0.push_back(mk(1'b0, 32'h00000000, 1'b1, 1'b0));
        start(1'b0, 8'd0, 4'd2);
        cyc(1'b1, 8'h00);
        chk("len0_dummy_busy", 32'(busy0), 32'd1);
        cyc(1'b1, 8'h00);
        repeat (3) cyc(1'b0, 8'h00);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus expected finish");
        $fatal(1);
    end

endmodule
